// File: rtl/tpu_pkg.sv
// Shared types and address map for the tpuv1 matrix-unit sequencer.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    C_WAIT = 2'd1,
    MULT   = 2'd2
  } state_t;

  localparam logic [15:0] A_BASE     = 16'h0100;
  localparam logic [15:0] B_BASE     = 16'h0200;
  localparam logic [15:0] C_BASE     = 16'h0300;
  localparam logic [15:0] C_LAST     = 16'h037F;
  localparam logic [15:0] START_ADDR = 16'h0400;
  localparam logic [15:0] A_MASK     = 16'hFFC0;
  localparam logic [15:0] B_MASK     = 16'hFFC0;
  localparam logic [15:0] C_MASK     = 16'hFF80;

  function automatic int mult_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_addr_dec.sv
// Region decode of a host address into tpu_seq write targets.
module tpu_addr_dec
  import tpu_pkg::*;
#(
  parameter int ADDRW = 16
) (
  input  logic [ADDRW-1:0] addr,
  input  logic             r_w,
  output logic             is_a,
  output logic             is_b,
  output logic             is_c_lo,
  output logic             is_c_hi,
  output logic             is_start
);

  logic in_c;

  assign in_c = ((addr & ADDRW'(C_MASK)) == ADDRW'(C_BASE))
             && (addr <= ADDRW'(C_LAST));

  assign is_a     = r_w && ((addr & ADDRW'(A_MASK)) == ADDRW'(A_BASE));
  assign is_b     = r_w && ((addr & ADDRW'(B_MASK)) == ADDRW'(B_BASE));
  assign is_c_lo  = r_w && in_c && !addr[3];
  assign is_c_hi  = r_w && in_c && addr[3];
  assign is_start = r_w && (addr == ADDRW'(START_ADDR));

endmodule

// File: rtl/tpu_seq.sv
// Host-bus sequencer: strobes for memA/memB/array, C-row assembly,
// and the fixed-length multiply that holds off the host.
module tpu_seq
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      r_w,
  input  logic [ADDRW-1:0]          addr,
  input  logic [DATAW-1:0]          data_in,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic                      c_err,
  output logic                      wr_a,
  output logic [$clog2(DIM)-1:0]    a_row,
  output logic                      en_b,
  output logic                      wr_c,
  output logic [$clog2(DIM)-1:0]    c_row,
  output logic [DIM*BITS_C-1:0]     c_data,
  output logic                      rd_half,
  output logic                      en_sys
);

  localparam int RW = $clog2(DIM);
  localparam int MC = mult_cycles(DIM);
  localparam int CW = $clog2(MC);
  localparam logic [CW-1:0] LAST = CW'(MC - 1);

  if (DIM * BITS_C != 2 * DATAW || 2 * BITS_AB > BITS_C) begin : g_chk
    $error("tpu_seq: inconsistent width parameters");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [DATAW-1:0] c_lo, c_lo_nxt;
  logic [RW-1:0]    c_pend, c_pend_nxt;
  logic             c_err_nxt;
  logic             fresh;
  logic             wr;
  logic             is_a, is_b, is_c_lo, is_c_hi, is_start;

  tpu_addr_dec #(.ADDRW(ADDRW)) u_dec (
    .addr     (addr),
    .r_w      (r_w),
    .is_a     (is_a),
    .is_b     (is_b),
    .is_c_lo  (is_c_lo),
    .is_c_hi  (is_c_hi),
    .is_start (is_start)
  );

  assign ready   = (state != MULT);
  assign busy    = (state == MULT);
  assign en_sys  = (state == MULT);
  assign wr      = req && ready && r_w;
  assign a_row   = addr[3 +: RW];
  assign c_row   = addr[4 +: RW];
  assign rd_half = addr[3];
  assign c_data  = {data_in, c_lo};

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    c_lo_nxt   = c_lo;
    c_pend_nxt = c_pend;
    c_err_nxt  = c_err;
    wr_a       = 1'b0;
    en_b       = 1'b0;
    wr_c       = 1'b0;
    fresh      = 1'b0;
    if (state == MULT) begin
      count_nxt = count + 1'b1;
      if (count == LAST) begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    end else if (wr) begin
      fresh = 1'b1;
      // A mapped write other than the matching high half breaks the pair.
      if (state == C_WAIT) begin
        if (is_c_hi && c_row == c_pend) begin
          wr_c      = 1'b1;
          state_nxt = IDLE;
          fresh     = 1'b0;
        end else if (is_a || is_b || is_c_lo || is_c_hi || is_start) begin
          c_err_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      if (fresh) begin
        unique case (1'b1)
          is_a: wr_a = 1'b1;
          is_b: en_b = 1'b1;
          is_c_lo: begin
            c_lo_nxt   = data_in;
            c_pend_nxt = c_row;
            state_nxt  = C_WAIT;
          end
          is_c_hi: c_err_nxt = 1'b1;
          is_start: begin
            state_nxt = MULT;
            count_nxt = '0;
            c_err_nxt = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      c_lo   <= '0;
      c_pend <= '0;
      c_err  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      c_lo   <= c_lo_nxt;
      c_pend <= c_pend_nxt;
      c_err  <= c_err_nxt;
      done   <= (state == MULT) && (count == LAST);
    end
  end

endmodule
